dmux8x4_collect: RTL and testbench
==================================

# dmux8x4_collect

Serial-to-parallel demultiplexer that is the write-side counterpart of the 8-way, 4-bit-wide mux. It accepts a stream of 4-bit nibbles over a valid/ready handshake and steers each nibble into one of eight 4-bit output lanes O0..O7, in order, using an internal 3-bit lane index. After all eight lanes are filled it presents them as one frame under an output valid/ready handshake. Typical use: reassembling 32-bit words that a Mux8x4 front end serialized onto a 4-bit path.

## Interface

- No parameters; lane count 8 and lane width 4 are fixed.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous reset, active-high.
- I  in  4  input nibble.
- I_valid  in  1  I carries a nibble this cycle.
- I_ready  out  1  block accepts I this cycle.
- O0..O7  out  4 each  output lanes; Ok holds the k-th nibble of the current frame.
- O_valid  out  1  complete frame presented on O0..O7.
- O_ready  in  1  downstream consumes the frame this cycle.
- S  out  3  current lane index, i.e. the lane the next accepted nibble will be written to.

## Operation

- State:
  - lane registers L0..L7, 4 bits each, driving O0..O7 directly;
  - index register S, 3 bits;
  - full flag driving O_valid.
- Input accept: in_fire = I_valid & I_ready.
- Output consume: out_fire = O_valid & O_ready.
- I_ready = ~O_valid | O_ready. This is combinational from O_ready.
- On in_fire:
  - L[S] <= I; all other lanes hold;
  - S <= S + 1, modulo 8, so 7 wraps to 0;
  - if S == 7, O_valid <= 1.
- On out_fire without an in_fire that completes a frame: O_valid <= 0.
- Simultaneous out_fire and in_fire with S == 0 (only possible case, since O_valid implies S == 0):
  - O_valid <= 0;
  - L0 <= I;
  - S <= 1.
- While O_valid = 1 and O_ready = 0:
  - I_ready = 0;
  - no lane, S, or O_valid changes;
  - O0..O7 remain stable.
- I_valid is ignored when I_ready = 0. The block never drops or duplicates a nibble.
- Lanes are not cleared between frames. Lanes not yet written in a partial frame show stale data, and this is legal because O_valid = 0.
- State machine, encoded by (O_valid, S):
  - FILL(k) for k = 0..7: O_valid = 0, S = k. in_fire moves FILL(k) to FILL(k+1) for k < 7, and FILL(7) to FULL.
  - FULL: O_valid = 1, S = 0.
    - out_fire without in_fire -> FILL(0).
    - out_fire with in_fire -> FILL(1).

## Timing

- Reset (RESET high at a clock edge) sets L0..L7 = 0, S = 0, O_valid = 0.
  - I_ready = 1 in the cycle after reset.
  - RESET has priority over every other event.
  - A partial frame in progress is discarded, and so is a presented frame not yet consumed.
- Latency: O_valid rises on the edge that accepts the 8th nibble, so a frame is visible 1 cycle after its last nibble is accepted.
- Throughput: with I_valid and O_ready held high, one frame every 8 cycles. There are no bubbles.
- Outputs O0..O7, O_valid, and S are registered.
- I_ready is the only combinational output, and it depends on O_ready.

## Test plan

- Reset check: assert RESET for 2 cycles with I_valid = 1, I = 4'hF. Required: all Ok = 0, S = 0, O_valid = 0, and I_ready = 1 after release.
- Single frame: feed nibbles 1,2,...,8 back-to-back with O_ready = 0.
  - O_valid = 1 exactly on the cycle after the 8th accept.
  - O0..O7 = 1..8, S = 0.
  - I_ready = 0 until O_ready is asserted.
- Backpressure hold: with the frame full, keep O_ready = 0 for 5 cycles while driving I_valid = 1, I = 4'hA.
  - Lanes, S, and O_valid stay unchanged.
  - After O_ready pulses, the next accepted nibble is 4'hA into O0.
- Streaming: O_ready = 1 and I_valid = 1 continuously with nibbles 0..15 repeating.
  - Frames {0..7} and {8..15} are each seen with O_valid = 1 for exactly 1 cycle.
  - No bubble occurs on I_ready.
- Input gaps: 8 nibbles 8'h?C with I_valid toggling 1,0,1,0,... Required: S increments only on in_fire, and the frame completes after the 8th valid nibble.
- Reset mid-frame: accept 3 nibbles, pulse RESET, then send 8 new nibbles 9..F,0. Required: the frame shows only the new nibbles, in order, and O_valid rises after the 8th new accept.

Source files
------------

// File: rtl/dmux8x4_collect.sv
// dmux8x4_collect: collects eight 4-bit nibbles into lanes O0..O7 and presents them as one frame
module dmux8x4_collect (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] I,
  input  logic       I_valid,
  output logic       I_ready,
  output logic [3:0] O0,
  output logic [3:0] O1,
  output logic [3:0] O2,
  output logic [3:0] O3,
  output logic [3:0] O4,
  output logic [3:0] O5,
  output logic [3:0] O6,
  output logic [3:0] O7,
  output logic       O_valid,
  input  logic       O_ready,
  output logic [2:0] S
);
  logic [3:0] lane_q [8];
  logic [3:0] lane_d [8];
  logic [2:0] idx_q, idx_d;
  logic       full_q, full_d;
  logic       in_fire, out_fire;
  always_comb begin
    I_ready  = ~full_q | O_ready;
    in_fire  = I_valid & I_ready;
    out_fire = full_q & O_ready;
    lane_d   = lane_q;
    if (in_fire) lane_d[idx_q] = I;
    idx_d    = in_fire ? idx_q + 3'd1 : idx_q;
    full_d   = (in_fire && idx_q == 3'd7) ? 1'b1 : out_fire ? 1'b0 : full_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lane_q <= '{default: 4'h0};
      idx_q  <= 3'd0;
      full_q <= 1'b0;
    end else begin
      lane_q <= lane_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end
  assign {O7, O6, O5, O4, O3, O2, O1, O0} =
    {lane_q[7], lane_q[6], lane_q[5], lane_q[4], lane_q[3], lane_q[2], lane_q[1], lane_q[0]};
  assign O_valid = full_q;
  assign S       = idx_q;
endmodule

// File: tb/tb_dmux8x4_collect.sv
// tb_dmux8x4_collect: directed checks of frame collection, backpressure, streaming and reset
module tb_dmux8x4_collect;
  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] I = 4'hF;
  logic       I_valid = 1'b1;
  logic       I_ready;
  logic [3:0] O0, O1, O2, O3, O4, O5, O6, O7;
  logic       O_valid;
  logic       O_ready = 1'b0;
  logic [2:0] S;
  logic [31:0] frame;
  int checks = 0;
  int errors = 0;
  int vcount;
  logic [2:0] exp_s;

  dmux8x4_collect dut (
    .CLK(CLK), .RESET(RESET), .I(I), .I_valid(I_valid), .I_ready(I_ready),
    .O0(O0), .O1(O1), .O2(O2), .O3(O3), .O4(O4), .O5(O5), .O6(O6), .O7(O7),
    .O_valid(O_valid), .O_ready(O_ready), .S(S)
  );

  assign frame = {O7, O6, O5, O4, O3, O2, O1, O0};

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset held two cycles with a valid nibble pending
    tick();
    tick();
    RESET = 1'b0;
    I_valid = 1'b0;
    #1;
    chk("rst_frame", frame, 32'h0);
    chk("rst_s", {29'd0, S}, 32'd0);
    chk("rst_ovalid", {31'd0, O_valid}, 32'd0);
    chk("rst_iready", {31'd0, I_ready}, 32'd1);

    // single frame 1..8 with no downstream consumer
    for (int n = 1; n <= 8; n++) begin
      I = n[3:0];
      I_valid = 1'b1;
      #1;
      chk("sf_iready", {31'd0, I_ready}, 32'd1);
      tick();
      if (n < 8) begin
        chk("sf_ovalid_lo", {31'd0, O_valid}, 32'd0);
        chk("sf_s", {29'd0, S}, n);
      end
    end
    chk("sf_ovalid_hi", {31'd0, O_valid}, 32'd1);
    chk("sf_frame", frame, 32'h87654321);
    chk("sf_s0", {29'd0, S}, 32'd0);
    chk("sf_iready_lo", {31'd0, I_ready}, 32'd0);

    // backpressure: input must be ignored while the frame waits
    I = 4'hA;
    I_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_frame", frame, 32'h87654321);
      chk("bp_ovalid", {31'd0, O_valid}, 32'd1);
      chk("bp_s", {29'd0, S}, 32'd0);
      chk("bp_iready", {31'd0, I_ready}, 32'd0);
    end
    O_ready = 1'b1;
    #1;
    chk("bp_iready_pass", {31'd0, I_ready}, 32'd1);
    tick();
    O_ready = 1'b0;
    I_valid = 1'b0;
    chk("bp_ovalid_clr", {31'd0, O_valid}, 32'd0);
    chk("bp_s1", {29'd0, S}, 32'd1);
    chk("bp_frame_a", frame, 32'h8765432A);

    // streaming after a fresh reset
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    O_ready = 1'b1;
    I_valid = 1'b1;
    vcount = 0;
    for (int c = 0; c < 24; c++) begin
      I = c[3:0];
      #1;
      chk("st_iready", {31'd0, I_ready}, 32'd1);
      tick();
      if (O_valid) vcount++;
      if (c == 7)  chk("st_frame0", frame, 32'h76543210);
      if (c == 8)  chk("st_after0", {31'd0, O_valid}, 32'd0);
      if (c == 8)  chk("st_lane0", frame, 32'h76543218);
      if (c == 15) chk("st_frame1", frame, 32'hFEDCBA98);
      if (c == 16) chk("st_after1", {31'd0, O_valid}, 32'd0);
      if (c == 23) chk("st_frame2", frame, 32'h76543210);
    end
    chk("st_vcount", vcount, 32'd3);
    I_valid = 1'b0;
    tick();
    O_ready = 1'b0;
    chk("st_drain", {31'd0, O_valid}, 32'd0);
    chk("st_drain_s", {29'd0, S}, 32'd0);

    // input gaps: only valid cycles advance S; gap cycles carry garbage
    exp_s = 3'd0;
    for (int c = 0; c < 16; c++) begin
      I_valid = (c % 2 == 0);
      I = I_valid ? 4'hC : 4'h3;
      tick();
      if (I_valid) exp_s = exp_s + 3'd1;
      chk("gap_s", {29'd0, S}, {29'd0, exp_s});
      chk("gap_ovalid", {31'd0, O_valid}, (c >= 14) ? 32'd1 : 32'd0);
    end
    chk("gap_frame", frame, 32'hCCCCCCCC);
    I_valid = 1'b0;
    O_ready = 1'b1;
    tick();
    O_ready = 1'b0;
    chk("gap_drain", {31'd0, O_valid}, 32'd0);

    // reset mid-frame discards the partial frame
    for (int n = 1; n <= 3; n++) begin
      I = n[3:0];
      I_valid = 1'b1;
      tick();
    end
    chk("mid_s3", {29'd0, S}, 32'd3);
    I_valid = 1'b0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("mid_rst_s", {29'd0, S}, 32'd0);
    chk("mid_rst_frame", frame, 32'h0);
    for (int n = 0; n < 8; n++) begin
      I = 4'h9 + n[3:0];
      I_valid = 1'b1;
      tick();
      chk("mid_ovalid", {31'd0, O_valid}, (n == 7) ? 32'd1 : 32'd0);
    end
    chk("mid_frame", frame, 32'h0FEDCBA9);
    I_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
